// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data width, parity mode and stop-bit count.
// The baud divisor is fixed at elaboration time.
// A one-entry holding register behind a valid/ready handshake lets a second word
// queue up during a frame, so frames can go out back-to-back with no idle gap.
module uart_tx_frame #(
  parameter int unsigned CLK_FREQ  = 32000000,
  parameter int unsigned BAUD_RATE = 19200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx,
  output logic                 tx_active,
  output logic                 done_tx
);

  localparam int unsigned CLOCK_DIVIDE = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLOCK_DIVIDE > 2) ? $clog2(CLOCK_DIVIDE) : 1;

  // Reject unsupported configurations at elaboration
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (CLOCK_DIVIDE < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 r_tx;
  logic                 r_tx_active;
  logic                 r_done_tx;

  logic w_accept;
  logic w_bit_end;
  logic w_last_stop;
  logic w_frame_end;
  logic w_done_next;

  // Parity over the whole word as latched at load time
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (^word) ^ (PARITY == 2);
  endfunction

  assign w_accept    = tx_valid & ~r_hold_full;
  assign w_bit_end   = (r_cnt == CNT_W'(CLOCK_DIVIDE - 1));
  assign w_last_stop = (r_bit_idx == 4'(STOP_BITS - 1));
  assign w_frame_end = (r_state == StStop) && w_bit_end && w_last_stop;
  // done_tx is registered, so raise it one clk ahead of the final stop clk
  assign w_done_next = (r_state == StStop) && w_last_stop &&
                       (r_cnt == CNT_W'(CLOCK_DIVIDE - 2));

  assign tx_ready  = ~r_hold_full;
  assign tx        = r_tx;
  assign tx_active = r_tx_active;
  assign done_tx   = r_done_tx;

  // Frame sequencer, holding register and registered line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_done_tx   <= 1'b0;
    end else begin
      r_done_tx <= w_done_next;

      // Mid-frame accepts park in the holding register; IDLE and the final
      // stop clk load the shift register directly instead.
      if (w_accept && (r_state != StIdle) && !w_frame_end) begin
        r_hold      <= tx_data_in;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          r_tx        <= 1'b1;
          r_tx_active <= 1'b0;
          r_cnt       <= '0;
          r_bit_idx   <= '0;
          if (w_accept) begin
            r_shift     <= tx_data_in;
            r_par       <= parity_of(tx_data_in);
            r_state     <= StStart;
            r_tx        <= 1'b0;
            r_tx_active <= 1'b1;
          end
        end

        StStart: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= StData;
            r_tx      <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StData: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 4'(DATA_BITS - 1)) begin
              r_bit_idx <= '0;
              if (PARITY != 0) begin
                r_state <= StParity;
                r_tx    <= r_par;
              end else begin
                r_state <= StStop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StParity: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= StStop;
            r_tx      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StStop: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_last_stop) begin
              r_bit_idx <= '0;
              if (r_hold_full) begin
                r_shift     <= r_hold;
                r_par       <= parity_of(r_hold);
                r_hold_full <= 1'b0;
                r_state     <= StStart;
                r_tx        <= 1'b0;
              end else if (w_accept) begin
                r_shift <= tx_data_in;
                r_par   <= parity_of(tx_data_in);
                r_state <= StStart;
                r_tx    <= 1'b0;
              end else begin
                r_state     <= StIdle;
                r_tx        <= 1'b1;
                r_tx_active <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state     <= StIdle;
          r_tx        <= 1'b1;
          r_tx_active <= 1'b0;
          r_cnt       <= '0;
          r_bit_idx   <= '0;
        end
      endcase
    end
  end

endmodule
